// File: rtl/decode_pkg.sv
// Shared decode types: opcode constants, functional-unit and ALU-op codes,
// and the decoded-entry bundle carried through the decode buffer.
package decode_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FU_NONE = 2'b00,
        FU_ALU  = 2'b01,
        FU_BRU  = 2'b10,
        FU_LSU  = 2'b11
    } fu_e;

    typedef enum logic [2:0] {
        ALU_MEM   = 3'b000,
        ALU_BR    = 3'b001,
        ALU_OP    = 3'b010,
        ALU_OPIMM = 3'b011,
        ALU_LUI   = 3'b100,
        ALU_AUIPC = 3'b101,
        ALU_JALR  = 3'b110,
        ALU_JAL   = 3'b111
    } aluop_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        aluop_e     aluop;
        logic [6:0] opcode;
        fu_e        fu;
        logic [2:0] func3;
        logic [6:0] func7;
        logic       rd_we;
        logic       illegal;
    } dec_entry_t;

    localparam int DEC_W = $bits(dec_entry_t);

    function automatic logic [4:0] f_rs1(input logic [31:0] i);
        return i[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] i);
        return i[24:20];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] i);
        return i[11:7];
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32 decode of one raw instruction into a decoded entry.
// Unknown opcodes yield an all-zero entry flagged illegal, opcode preserved.
module instr_decoder
    import decode_pkg::*;
(
    input  logic [31:0]      instr,
    output logic [DEC_W-1:0] entry
);

    dec_entry_t d;
    logic [6:0] opc;
    logic       wr;

    assign opc = instr[6:0];

    always_comb begin
        d        = '0;
        d.opcode = opc;
        wr       = 1'b0;
        unique case (1'b1)
            (opc == OPC_OP_IMM): begin
                d.rs1   = f_rs1(instr);
                d.rd    = f_rd(instr);
                d.aluop = ALU_OPIMM;
                d.fu    = FU_ALU;
                d.func3 = instr[14:12];
                d.func7 = instr[31:25];
                wr      = 1'b1;
            end
            (opc == OPC_LUI): begin
                d.rd    = f_rd(instr);
                d.aluop = ALU_LUI;
                d.fu    = FU_ALU;
                wr      = 1'b1;
            end
            (opc == OPC_OP): begin
                d.rs1   = f_rs1(instr);
                d.rs2   = f_rs2(instr);
                d.rd    = f_rd(instr);
                d.aluop = ALU_OP;
                d.fu    = FU_ALU;
                d.func3 = instr[14:12];
                d.func7 = instr[31:25];
                wr      = 1'b1;
            end
            (opc == OPC_LOAD): begin
                d.rs1   = f_rs1(instr);
                d.rd    = f_rd(instr);
                d.aluop = ALU_MEM;
                d.fu    = FU_LSU;
                d.func3 = instr[14:12];
                wr      = 1'b1;
            end
            (opc == OPC_STORE): begin
                d.rs1   = f_rs1(instr);
                d.rs2   = f_rs2(instr);
                d.aluop = ALU_MEM;
                d.fu    = FU_LSU;
                d.func3 = instr[14:12];
            end
            (opc == OPC_BRANCH): begin
                d.rs1   = f_rs1(instr);
                d.rs2   = f_rs2(instr);
                d.aluop = ALU_BR;
                d.fu    = FU_BRU;
                d.func3 = instr[14:12];
            end
            (opc == OPC_JALR): begin
                d.rs1   = f_rs1(instr);
                d.rd    = f_rd(instr);
                d.aluop = ALU_JALR;
                d.fu    = FU_ALU;
                d.func3 = instr[14:12];
                wr      = 1'b1;
            end
            (opc == OPC_AUIPC): begin
                d.rd    = f_rd(instr);
                d.aluop = ALU_AUIPC;
                d.fu    = FU_ALU;
                wr      = 1'b1;
            end
            (opc == OPC_JAL): begin
                d.rd    = f_rd(instr);
                d.aluop = ALU_JAL;
                d.fu    = FU_ALU;
                wr      = 1'b1;
            end
            default: begin
                d.illegal = 1'b1;
            end
        endcase
        // x0 is hardwired zero, so a write to it is never requested
        d.rd_we = wr && (d.rd != 5'd0);
    end

    assign entry = d;

endmodule

// File: rtl/decode_buffer.sv
// Decode stage buffer: decodes fetched instructions and queues them in a
// small FIFO toward rename, with flush and valid/ready on both sides.
module decode_buffer
    import decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [31:0]              instr,
    input  logic [PC_W-1:0]          instr_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [4:0]               dec_rs1,
    output logic [4:0]               dec_rs2,
    output logic [4:0]               dec_rd,
    output logic [2:0]               dec_aluop,
    output logic [6:0]               dec_opcode,
    output logic [1:0]               dec_fu,
    output logic [2:0]               dec_func3,
    output logic [6:0]               dec_func7,
    output logic                     dec_rd_we,
    output logic                     dec_illegal,
    output logic [PC_W-1:0]          dec_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DEC_W-1:0] new_entry;
    logic [DEC_W-1:0] mem [DEPTH];
    logic [PC_W-1:0]  pcm [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             push;
    logic             pop;
    dec_entry_t       head;

    instr_decoder u_dec (
        .instr (instr),
        .entry (new_entry)
    );

    // rst_n gates ready so nothing is offered to fetch while reset is held
    assign instr_ready = rst_n && (cnt != FULL_CNT) && !flush;
    assign dec_valid   = (cnt != '0);
    assign push        = instr_valid && instr_ready;
    assign pop         = dec_valid && dec_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= new_entry;
            pcm[wptr] <= instr_pc;
        end
    end

    // storage is not reset, so outputs are forced to zero when empty
    assign head   = dec_valid ? dec_entry_t'(mem[rptr]) : '0;
    assign dec_pc = dec_valid ? pcm[rptr] : '0;

    assign dec_rs1     = head.rs1;
    assign dec_rs2     = head.rs2;
    assign dec_rd      = head.rd;
    assign dec_aluop   = head.aluop;
    assign dec_opcode  = head.opcode;
    assign dec_fu      = head.fu;
    assign dec_func3   = head.func3;
    assign dec_func7   = head.func7;
    assign dec_rd_we   = head.rd_we;
    assign dec_illegal = head.illegal;
    assign count       = cnt;

endmodule

// File: tb/tb_decode_buffer.sv
// Scoreboard bench for decode_buffer: driver pushes expected decodes,
// a negedge monitor pops and compares whatever the buffer presents.
module tb_decode_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  aluop;
        logic [6:0]  opcode;
        logic [1:0]  fu;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        we;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [2:0]  dec_aluop;
    logic [6:0]  dec_opcode;
    logic [1:0]  dec_fu;
    logic [2:0]  dec_func3;
    logic [6:0]  dec_func7;
    logic        dec_rd_we, dec_illegal;
    logic [31:0] dec_pc;
    logic [2:0]  count;

    exp_t q[$];
    logic exp_ready = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    decode_buffer #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_aluop(dec_aluop), .dec_opcode(dec_opcode), .dec_fu(dec_fu),
        .dec_func3(dec_func3), .dec_func7(dec_func7),
        .dec_rd_we(dec_rd_we), .dec_illegal(dec_illegal),
        .dec_pc(dec_pc), .count(count)
    );

    // Reference decode straight from the opcode table: which fields exist
    // per format, then x0 suppression for the write enable.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        bit r1, r2, wd, k3, k7;
        e = '0;
        {r1, r2, wd, k3, k7} = '0;
        e.opcode = i[6:0];
        e.pc = pc;
        case (i[6:0])
            7'h13: begin r1 = 1; wd = 1; k3 = 1; k7 = 1; e.aluop = 3; e.fu = 1; end
            7'h37: begin wd = 1; e.aluop = 4; e.fu = 1; end
            7'h33: begin r1 = 1; r2 = 1; wd = 1; k3 = 1; k7 = 1; e.aluop = 2; e.fu = 1; end
            7'h03: begin r1 = 1; wd = 1; k3 = 1; e.aluop = 0; e.fu = 3; end
            7'h23: begin r1 = 1; r2 = 1; k3 = 1; e.aluop = 0; e.fu = 3; end
            7'h63: begin r1 = 1; r2 = 1; k3 = 1; e.aluop = 1; e.fu = 2; end
            7'h67: begin r1 = 1; wd = 1; k3 = 1; e.aluop = 6; e.fu = 1; end
            7'h17: begin wd = 1; e.aluop = 5; e.fu = 1; end
            7'h6F: begin wd = 1; e.aluop = 7; e.fu = 1; end
            default: e.ill = 1'b1;
        endcase
        if (r1) e.rs1 = i[19:15];
        if (r2) e.rs2 = i[24:20];
        if (wd) e.rd = i[11:7];
        if (k3) e.f3 = i[14:12];
        if (k7) e.f7 = i[31:25];
        e.we = wd && (i[11:7] != 5'd0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: checks occupancy/handshakes against the model and the head
    // entry whenever one is presented, then retires it on a real pop.
    always @(negedge clk) begin
        exp_t got;
        logic er;
        if (rst_n) begin
            er = (q.size() < DEPTH) && !flush;
            n_checks += 3;
            if (int'(count) != q.size()) begin
                n_fail++;
                $display("FAIL count: got %0d expected %0d", count, q.size());
            end
            if (instr_ready !== er) begin
                n_fail++;
                $display("FAIL instr_ready: got %b expected %b", instr_ready, er);
            end
            if (dec_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL dec_valid: got %b expected %b", dec_valid, q.size() != 0);
            end
            if (dec_valid && q.size() > 0) begin
                got = {dec_rs1, dec_rs2, dec_rd, dec_aluop, dec_opcode, dec_fu,
                       dec_func3, dec_func7, dec_rd_we, dec_illegal, dec_pc};
                n_checks++;
                if (got !== q[0]) begin
                    n_fail++;
                    $display("FAIL head_entry: got %h expected %h", got, q[0]);
                end
            end
            if (flush) q.delete();
            else if (dec_valid && dec_ready && q.size() > 0) void'(q.pop_front());
            exp_ready = er;
        end else begin
            exp_ready = 1'b0;
        end
    end

    // One cycle: record an accepted push, then land just after the edge.
    task automatic step();
        @(negedge clk);
        #1;
        if (instr_valid && exp_ready) q.push_back(model(instr, instr_pc));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] pc);
        instr = i;
        instr_pc = pc;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    logic [6:0] opc_tab [10] = '{7'h13, 7'h37, 7'h33, 7'h03, 7'h23,
                                 7'h63, 7'h67, 7'h17, 7'h6F, 7'h7F};

    initial begin
        logic [31:0] pc;
        logic [31:0] r;
        rst_n = 1'b0;
        flush = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        instr_pc = '0;
        dec_ready = 1'b0;
        #12;
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_instr_ready", 64'(instr_ready), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_dec_pc", 64'(dec_pc), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        dec_ready = 1'b1;
        send(32'h00500093, 32'h1000);
        chk("addi_valid", 64'(dec_valid), 64'd1);
        chk("addi_rs1", 64'(dec_rs1), 64'd0);
        chk("addi_rd", 64'(dec_rd), 64'd1);
        chk("addi_aluop", 64'(dec_aluop), 64'd3);
        chk("addi_fu", 64'(dec_fu), 64'd1);
        chk("addi_func3", 64'(dec_func3), 64'd0);
        chk("addi_rd_we", 64'(dec_rd_we), 64'd1);
        step();

        send(32'h002081B3, 32'h1004);
        chk("add_rs1", 64'(dec_rs1), 64'd1);
        chk("add_rs2", 64'(dec_rs2), 64'd2);
        chk("add_rd", 64'(dec_rd), 64'd3);
        chk("add_aluop", 64'(dec_aluop), 64'd2);
        chk("add_fu", 64'(dec_fu), 64'd1);
        chk("add_func7", 64'(dec_func7), 64'd0);
        chk("add_rd_we", 64'(dec_rd_we), 64'd1);
        step();

        send(32'h0020A423, 32'h1008);
        chk("sw_rs1", 64'(dec_rs1), 64'd1);
        chk("sw_rs2", 64'(dec_rs2), 64'd2);
        chk("sw_rd", 64'(dec_rd), 64'd0);
        chk("sw_fu", 64'(dec_fu), 64'd3);
        chk("sw_func3", 64'(dec_func3), 64'd2);
        chk("sw_rd_we", 64'(dec_rd_we), 64'd0);
        step();

        send(32'hFFFFFFFF, 32'h100C);
        chk("ill_illegal", 64'(dec_illegal), 64'd1);
        chk("ill_fu", 64'(dec_fu), 64'd0);
        chk("ill_opcode", 64'(dec_opcode), 64'h7F);
        step();

        // fill past capacity with rename stalled
        dec_ready = 1'b0;
        pc = 32'h2000;
        instr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            instr = 32'h00100013 + (32'(k) << 7);
            instr_pc = pc;
            pc += 4;
            step();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(instr_ready), 64'd0);
        dec_ready = 1'b1;
        instr = 32'h00000033;
        instr_pc = 32'h2FF0;
        step();
        chk("full_pop_push_count", 64'(count), 64'd3);
        instr_valid = 1'b0;
        repeat (3) step();
        chk("drained_valid", 64'(dec_valid), 64'd0);

        // flush with a same-cycle push
        dec_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(32'h00000037 | (32'(k + 1) << 7), 32'h3000 + 32'(k * 4));
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1'b1;
        instr_valid = 1'b1;
        instr = 32'h00500093;
        instr_pc = 32'h3100;
        step();
        flush = 1'b0;
        instr_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(dec_valid), 64'd0);
        step();
        chk("flush_push_lost", 64'(dec_valid), 64'd0);

        // random traffic across pointer wrap, reset mid-stream
        pc = 32'h4000;
        for (int k = 0; k < 80; k++) begin
            r = $urandom;
            instr = {r[31:7], opc_tab[$urandom_range(0, 9)]};
            instr_pc = pc;
            instr_valid = ($urandom_range(0, 3) != 0);
            dec_ready = $urandom_range(0, 1);
            step();
            if (instr_valid) pc += 4;
            if (k == 50) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_dec_valid", 64'(dec_valid), 64'd0);
                chk("midrst_instr_ready", 64'(instr_ready), 64'd0);
                chk("midrst_count", 64'(count), 64'd0);
                q.delete();
                instr_valid = 1'b0;
                repeat (2) step();
                rst_n = 1'b1;
            end
        end

        instr_valid = 1'b0;
        dec_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() > 0; k++) step();
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_valid", 64'(dec_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
